// File: rtl/mag_to_bcd_seq.sv
// Sequential signed-integer to packed-BCD converter using a one-bit-per-cycle
// shift-add-3 engine, with valid/ready handshakes on input and output.
module mag_to_bcd_seq #(
  parameter int WIDTH     = 24,
  parameter int DIGITS    = 8,
  parameter int SIGNED_IN = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_sign,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4*DIGITS-1:0]           out_bcd,
  output logic                          out_sign,
  output logic [$clog2(DIGITS+1)-1:0]   out_ndig,
  output logic                          out_ovf,
  output logic [1:0]                    dbg_state
);

  // Handshake: a word transfers on any rising edge where valid and ready are
  // both high; valid holds its payload until that edge, ready may toggle freely.

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int NW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] mag_q;
  logic [BW-1:0]    bcd_q;
  logic             ovf_q;
  logic             sign_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] load_mag;
  logic             load_sign;
  logic             accept;
  logic             last_shift;
  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_next;
  logic [WIDTH-1:0] mag_next;
  logic             ovf_next;
  logic [NW-1:0]    ndig_next;

  assign in_ready   = (state_q == IDLE) & ~rst;
  assign out_valid  = (state_q == DONE);
  assign dbg_state  = state_q;
  assign accept     = in_valid & in_ready;
  assign last_shift = (state_q == SHIFT) && (cnt_q == '0);

  // Two's-complement negation stays in WIDTH bits so the most negative value
  // maps onto its own bit pattern as an unsigned magnitude.
  always_comb begin
    load_mag  = in_data;
    load_sign = in_sign & (|in_data);
    if (SIGNED_IN != 0) begin
      load_sign = in_data[WIDTH-1];
      load_mag  = load_sign ? (~in_data + WIDTH'(1)) : in_data;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
    mag_next = {mag_q[WIDTH-2:0], 1'b0};
    ovf_next = ovf_q | bcd_adj[BW-1];
    ndig_next = NW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_next[4*i +: 4] != 4'd0) ndig_next = NW'(i + 1);
    end
    if (ovf_next) ndig_next = NW'(DIGITS);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q    <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      out_bcd  <= '0;
      out_sign <= 1'b0;
      out_ndig <= '0;
      out_ovf  <= 1'b0;
    end else begin
      if ((state_q == IDLE) && accept) begin
        mag_q  <= load_mag;
        sign_q <= load_sign;
        bcd_q  <= '0;
        ovf_q  <= 1'b0;
        cnt_q  <= CW'(WIDTH - 1);
      end
      if (state_q == SHIFT) begin
        bcd_q <= bcd_next;
        mag_q <= mag_next;
        ovf_q <= ovf_next;
        cnt_q <= cnt_q - CW'(1);
      end
      // Result fields only move on the edge that enters DONE.
      if (last_shift) begin
        out_bcd  <= bcd_next;
        out_sign <= sign_q;
        out_ovf  <= ovf_next;
        out_ndig <= ndig_next;
      end
    end
  end

endmodule
